// File: rtl/escalonador_de_contexto_pkg.sv
// Shared definitions for the privilege/quantum scheduler: state and trap-cause
// encodings plus default geometry.
package escalonador_de_contexto_pkg;

   typedef enum logic [1:0] {
      KERNEL = 2'b00,
      USER   = 2'b01,
      TRAP   = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_SYSCALL = 2'd1,
      CAUSE_QUANTUM = 2'd2,
      CAUSE_ILLEGAL = 2'd3
   } cause_t;

   localparam int ADDR_W_DEF    = 10;
   localparam int QUANT_W_DEF   = 16;
   localparam int TRAP_ADDR_DEF = 0;

endpackage

// File: rtl/escalonador_de_contexto_if.sv
// Control-unit <-> scheduler bundle: decoded mode pulses and PCs in, privilege,
// PC override and saved trap context out.
interface escalonador_de_contexto_if #(
   parameter int ADDR_W  = 10,
   parameter int QUANT_W = 16
);
   logic               instr_valid;
   logic               user_mode;
   logic               kernel_mode;
   logic               is_halt;
   logic [ADDR_W-1:0]  pc_current;
   logic [ADDR_W-1:0]  pc_next;
   logic               q_write;
   logic [QUANT_W-1:0] q_data;

   logic               mode_user;
   logic               pc_override;
   logic [ADDR_W-1:0]  trap_pc;
   logic               stall;
   logic [ADDR_W-1:0]  saved_pc;
   logic [1:0]         cause;
   logic [QUANT_W-1:0] quantum_left;

   modport master (
      output instr_valid, user_mode, kernel_mode, is_halt,
             pc_current, pc_next, q_write, q_data,
      input  mode_user, pc_override, trap_pc, stall,
             saved_pc, cause, quantum_left
   );

   modport slave (
      input  instr_valid, user_mode, kernel_mode, is_halt,
             pc_current, pc_next, q_write, q_data,
      output mode_user, pc_override, trap_pc, stall,
             saved_pc, cause, quantum_left
   );
endinterface

// File: rtl/escalonador_de_contexto_contador_de_quantum.sv
// Loadable down-counter that saturates at zero; expire flags the last
// instruction of the quantum (value == 1).
module contador_de_quantum #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic [W-1:0] value,
   output logic         expire
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its peers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (dec && value != '0) begin
         value <= value - W'(1);
      end
   end

   assign expire = (value == W'(1));

endmodule

// File: rtl/escalonador_de_contexto.sv
// Privilege-mode sequencer: exec/syscall mode switching, per-process instruction
// quantum and one-cycle trap to the kernel entry with saved PC and cause.
module escalonador_de_contexto
   import escalonador_de_contexto_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int QUANT_W   = QUANT_W_DEF,
   parameter int TRAP_ADDR = TRAP_ADDR_DEF
) (
   input logic                 clk,
   input logic                 rst,
   escalonador_de_contexto_if.slave bus
);

   state_t             state;
   cause_t             cause;
   logic               mode_user;
   logic [ADDR_W-1:0]  saved_pc;
   logic [QUANT_W-1:0] reload;

   logic               in_kernel;
   logic               in_user;
   logic               q_load;
   logic               q_dec;
   logic               q_expire;
   logic [QUANT_W-1:0] q_value;

   logic               trap_hit;
   cause_t             trap_cause;
   logic [ADDR_W-1:0]  trap_save;

   assign in_kernel = (state == KERNEL);
   assign in_user   = (state == USER);
   assign q_load    = in_kernel && bus.instr_valid && bus.user_mode;
   assign q_dec     = in_user && bus.instr_valid;

   contador_de_quantum #(.W(QUANT_W)) u_quantum (
      .clk        (clk),
      .rst        (rst),
      .load       (q_load),
      .load_value (reload),
      .dec        (q_dec),
      .value      (q_value),
      .expire     (q_expire)
   );

   // Trap arbitration: illegal beats syscall beats quantum expiry.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      trap_hit   = 1'b0;
      trap_cause = CAUSE_NONE;
      trap_save  = '0;
      if (in_user && bus.instr_valid) begin
         if (bus.user_mode || bus.is_halt) begin
            trap_hit   = 1'b1;
            trap_cause = CAUSE_ILLEGAL;
            trap_save  = bus.pc_current;
         end else if (bus.kernel_mode) begin
            trap_hit   = 1'b1;
            trap_cause = CAUSE_SYSCALL;
            trap_save  = bus.pc_current + ADDR_W'(1);
         end else if (reload != '0 && q_expire) begin
            trap_hit   = 1'b1;
            trap_cause = CAUSE_QUANTUM;
            trap_save  = bus.pc_next;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= KERNEL;
         mode_user <= 1'b0;
         cause     <= CAUSE_NONE;
         saved_pc  <= '0;
         reload    <= '0;
      end else begin
         case (state)
            KERNEL: begin
               if (bus.instr_valid) begin
                  if (bus.q_write) reload <= bus.q_data;
                  if (bus.user_mode) begin
                     state     <= USER;
                     mode_user <= 1'b1;
                     cause     <= CAUSE_NONE;
                  end
               end
            end
            USER: begin
               if (trap_hit) begin
                  state     <= TRAP;
                  mode_user <= 1'b0;
                  cause     <= trap_cause;
                  saved_pc  <= trap_save;
               end
            end
            TRAP: begin
               state <= KERNEL;
            end
            default: begin
               state     <= KERNEL;
               mode_user <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mode_user    = mode_user;
   assign bus.pc_override  = (state == TRAP);
   assign bus.stall        = (state == TRAP);
   assign bus.trap_pc      = ADDR_W'(TRAP_ADDR);
   assign bus.saved_pc     = saved_pc;
   assign bus.cause        = cause;
   assign bus.quantum_left = q_value;

endmodule

// File: tb/tb_escalonador_de_contexto.sv
// Bench for escalonador_de_contexto: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_escalonador_de_contexto;

   localparam int AW = 10;
   localparam int QW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   escalonador_de_contexto_if #(.ADDR_W(AW), .QUANT_W(QW)) bus ();

   escalonador_de_contexto #(.ADDR_W(AW), .QUANT_W(QW), .TRAP_ADDR(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: privilege flag, "trap in progress" flag, arithmetic counters.
   bit          m_user;
   bit          m_trap;
   int unsigned m_reload;
   int unsigned m_q;
   int unsigned m_saved;
   int unsigned m_cause;

   task automatic model_reset();
      m_user = 0; m_trap = 0; m_reload = 0; m_q = 0; m_saved = 0; m_cause = 0;
   endtask

   task automatic check(string tag, int unsigned obs, int unsigned exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      check({tag, ".mode_user"},    32'(bus.mode_user),    32'(m_user));
      check({tag, ".pc_override"},  32'(bus.pc_override),  32'(m_trap));
      check({tag, ".stall"},        32'(bus.stall),        32'(m_trap));
      check({tag, ".trap_pc"},      32'(bus.trap_pc),      0);
      check({tag, ".saved_pc"},     32'(bus.saved_pc),     m_saved);
      check({tag, ".cause"},        32'(bus.cause),        m_cause);
      check({tag, ".quantum_left"}, 32'(bus.quantum_left), m_q);
   endtask

   // One clock: drive inputs, advance the model, compare #1 after the edge.
   task automatic step(string tag, bit v, bit um, bit km, bit h, bit qw,
                       int unsigned qd, int unsigned pc, int unsigned pn);
      bit          n_user, n_trap;
      int unsigned n_reload, n_q, n_saved, n_cause;
      bus.instr_valid = v;  bus.user_mode = um; bus.kernel_mode = km;
      bus.is_halt     = h;  bus.q_write   = qw; bus.q_data = QW'(qd);
      bus.pc_current  = AW'(pc); bus.pc_next = AW'(pn);
      n_user = m_user; n_trap = 0; n_reload = m_reload; n_q = m_q;
      n_saved = m_saved; n_cause = m_cause;
      if (m_trap) begin
         n_user = 0;
      end else if (v && !m_user) begin
         if (um) begin
            n_user = 1; n_q = m_reload; n_cause = 0;
         end
         if (qw) n_reload = qd % (1 << QW);
      end else if (v && m_user) begin
         n_q = (m_q > 0) ? m_q - 1 : 0;
         if (um || h) begin
            n_trap = 1; n_cause = 3; n_saved = pc % (1 << AW);
         end else if (km) begin
            n_trap = 1; n_cause = 1; n_saved = (pc + 1) % (1 << AW);
         end else if (m_reload != 0 && m_q == 1) begin
            n_trap = 1; n_cause = 2; n_saved = pn % (1 << AW);
         end
         if (n_trap) n_user = 0;
      end
      @(posedge clk);
      #1;
      m_user = n_user; m_trap = n_trap; m_reload = n_reload; m_q = n_q;
      m_saved = n_saved; m_cause = n_cause;
      check_all(tag);
   endtask

   task automatic retire(string tag, int unsigned pc, int unsigned pn);
      step(tag, 1, 0, 0, 0, 0, 0, pc, pn);
   endtask

   task automatic idle(string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic async_reset(string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all({tag, ".async"});
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all({tag, ".held"});
   endtask

   initial begin
      bus.instr_valid = 0; bus.user_mode = 0; bus.kernel_mode = 0; bus.is_halt = 0;
      bus.q_write = 0; bus.q_data = '0; bus.pc_current = '0; bus.pc_next = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_all("reset");

      // Exec path with quantum 3 ending in a preemption trap.
      step("qwrite3", 1, 0, 0, 0, 1, 3, 10'h010, 10'h011);
      step("exec",    1, 1, 0, 0, 0, 0, 10'h020, 10'h100);
      check("exec.mode_user", 32'(bus.mode_user), 1);
      check("exec.q",         32'(bus.quantum_left), 3);
      retire("ret1", 10'h100, 10'h101);
      retire("ret2", 10'h101, 10'h102);
      retire("ret3", 10'h102, 10'h105);
      check("qtrap.override", 32'(bus.pc_override), 1);
      check("qtrap.saved",    32'(bus.saved_pc), 32'h105);
      check("qtrap.cause",    32'(bus.cause), 2);
      idle("qtrap.after");
      check("qtrap.kernel", 32'(bus.pc_override), 0);

      // Syscall at the top of the address space wraps the resume PC.
      step("exec2", 1, 1, 0, 0, 0, 0, 10'h030, 10'h200);
      step("sys_wrap", 1, 0, 1, 0, 0, 0, 10'h3FF, 10'h000);
      check("sys_wrap.saved", 32'(bus.saved_pc), 0);
      check("sys_wrap.cause", 32'(bus.cause), 1);
      check("sys_wrap.stall", 32'(bus.stall), 1);
      idle("sys_wrap.after");

      // Syscall coincident with quantum expiry reports syscall only.
      step("exec3", 1, 1, 0, 0, 0, 0, 10'h031, 10'h200);
      retire("pri.r1", 10'h200, 10'h201);
      retire("pri.r2", 10'h201, 10'h202);
      check("pri.q1", 32'(bus.quantum_left), 1);
      step("pri.sys", 1, 0, 1, 0, 0, 0, 10'h040, 10'h300);
      check("pri.cause", 32'(bus.cause), 1);
      check("pri.saved", 32'(bus.saved_pc), 32'h041);
      idle("pri.after");
      step("exec4", 1, 1, 0, 0, 0, 0, 10'h032, 10'h200);
      step("illegal", 1, 1, 0, 0, 0, 0, 10'h050, 10'h051);
      check("illegal.cause", 32'(bus.cause), 3);
      check("illegal.saved", 32'(bus.saved_pc), 32'h050);
      idle("illegal.after");
      step("exec_clr", 1, 1, 0, 0, 0, 0, 10'h033, 10'h200);
      check("exec_clr.cause", 32'(bus.cause), 0);
      step("halt_u", 1, 0, 0, 1, 0, 0, 10'h060, 10'h061);
      idle("halt_u.after");

      // Quantum disabled: long user run never traps.
      step("qwrite0", 1, 0, 0, 0, 1, 0, 10'h000, 10'h001);
      step("exec_nq", 1, 1, 0, 0, 0, 0, 10'h001, 10'h002);
      for (int i = 0; i < 70000; i++) retire("noq", i % 1024, (i + 1) % 1024);
      check("noq.user", 32'(bus.mode_user), 1);
      check("noq.q",    32'(bus.quantum_left), 0);
      step("noq.exit", 1, 0, 1, 0, 0, 0, 10'h070, 10'h071);
      idle("noq.after");

      // Frozen counter while stalled, qWrite ignored in user mode.
      step("qwrite5", 1, 0, 0, 0, 1, 5, 10'h000, 10'h001);
      step("exec5",   1, 1, 0, 0, 0, 0, 10'h001, 10'h002);
      repeat (10) idle("frozen");
      check("frozen.q", 32'(bus.quantum_left), 5);
      step("uqwrite", 1, 0, 0, 0, 1, 9, 10'h002, 10'h003);
      step("halt_trap", 1, 0, 0, 1, 0, 0, 10'h003, 10'h004);
      idle("halt_trap.after");
      step("exec6", 1, 1, 0, 0, 0, 0, 10'h004, 10'h005);
      check("reload_kept.q", 32'(bus.quantum_left), 5);
      step("back", 1, 0, 1, 0, 0, 0, 10'h005, 10'h006);
      idle("back.after");

      // Kernel ignores syscall and halt.
      step("k_sys",  1, 0, 1, 0, 0, 0, 10'h080, 10'h081);
      step("k_halt", 1, 0, 0, 1, 0, 0, 10'h081, 10'h082);
      check("k_ign.override", 32'(bus.pc_override), 0);

      // Reset mid-run from user mode, then from the TRAP cycle.
      step("pre_rst", 1, 1, 0, 0, 0, 0, 10'h090, 10'h091);
      async_reset("rst_user");
      step("exec_r0", 1, 1, 0, 0, 0, 0, 10'h001, 10'h002);
      check("rst_reload.q", 32'(bus.quantum_left), 0);
      step("trap_r", 1, 0, 1, 0, 0, 0, 10'h123, 10'h124);
      check("trap_r.override", 32'(bus.pc_override), 1);
      async_reset("rst_trap");

      // Random traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         step("rand",
              $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 6),
              $urandom_range(0, 1023), $urandom_range(0, 1023));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
